// File: rtl/dl_lshift_pipe.sv
//------------------------------------------------------------------------------
// Module      : dl_lshift_pipe
// Description : Pipelined log2 barrel left shifter (zero fill), one register
//               per shamt bit, valid/ready with global stall on backpressure.
//               Optional sticky overflow flag under `DL_LSHIFT_OVF_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dl_lshift_pipe #(
   parameter int NUM_BITS = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [NUM_BITS-1:0]         in,
   input  logic [$clog2(NUM_BITS)-1:0] shamt,
   output logic                        out_valid,
   input  logic                        out_ready,
`ifdef DL_LSHIFT_OVF_EN
   output logic                        out_ovf,
`endif
   output logic [NUM_BITS-1:0]         out
);

   localparam int NUM_SHIFT_BITS = $clog2(NUM_BITS);

   logic                                         w_en;
   logic [NUM_SHIFT_BITS:0][NUM_BITS-1:0]        w_data;
   logic [NUM_SHIFT_BITS:0]                      w_vld;
   logic [NUM_SHIFT_BITS-1:0][NUM_SHIFT_BITS-1:0] w_sh;
`ifdef DL_LSHIFT_OVF_EN
   logic [NUM_SHIFT_BITS:0]                      w_ovf;
`endif

   assign w_en      = !w_vld[NUM_SHIFT_BITS] || out_ready;
   assign in_ready  = w_en;
   assign w_data[0] = in;
   assign w_vld[0]  = in_valid;
   assign w_sh[0]   = shamt;
   assign out       = w_data[NUM_SHIFT_BITS];
   assign out_valid = w_vld[NUM_SHIFT_BITS];
`ifdef DL_LSHIFT_OVF_EN
   assign w_ovf[0]  = 1'b0;
   assign out_ovf   = w_ovf[NUM_SHIFT_BITS];
`endif

   for (genvar k = 0; k < NUM_SHIFT_BITS; k++) begin : g_stage
      localparam int C_STEP = 1 << k;

      logic [NUM_BITS-1:0] w_shifted;
      logic [NUM_BITS-1:0] r_data;
      logic                r_vld;

      // The shamt word is shifted right each stage, so bit 0 is always this stage's control.
      assign w_shifted = w_sh[k][0] ? (w_data[k] << C_STEP) : w_data[k];

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_data <= '0;
            r_vld  <= 1'b0;
         end else if (w_en) begin
            r_data <= w_shifted;
            r_vld  <= w_vld[k];
         end
      end

      assign w_data[k+1] = r_data;
      assign w_vld[k+1]  = r_vld;

      if (k < NUM_SHIFT_BITS - 1) begin : g_sh
         logic [NUM_SHIFT_BITS-1:0] r_sh;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_sh <= '0;
            end else if (w_en) begin
               r_sh <= w_sh[k] >> 1;
            end
         end

         assign w_sh[k+1] = r_sh;
      end

`ifdef DL_LSHIFT_OVF_EN
      // Bits lost in this stage are the top C_STEP bits of its input.
      logic w_lost;
      logic r_ovf;

      assign w_lost = w_sh[k][0] && (|w_data[k][NUM_BITS-1 -: C_STEP]);

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_ovf <= 1'b0;
         end else if (w_en) begin
            r_ovf <= w_ovf[k] | w_lost;
         end
      end

      assign w_ovf[k+1] = r_ovf;
`endif
   end

endmodule

`default_nettype wire

// File: tb/tb_dl_lshift_pipe.sv
//------------------------------------------------------------------------------
// Module      : tb_dl_lshift_pipe
// Description : Directed self-checking bench for dl_lshift_pipe (NUM_BITS=32).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dl_lshift_pipe;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [4:0]  shamt;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
`ifdef DL_LSHIFT_OVF_EN
   logic        out_ovf;
`endif

   int checks;
   int errors;

   dl_lshift_pipe #(.NUM_BITS(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in        (in_data),
      .shamt     (shamt),
      .out_valid (out_valid),
      .out_ready (out_ready),
`ifdef DL_LSHIFT_OVF_EN
      .out_ovf   (out_ovf),
`endif
      .out       (out_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] exp;
      logic        exp_v;
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      shamt     = '0;
      out_ready = 1'b1;

      // Reset state
      repeat (2) step();
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out", out_data, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef DL_LSHIFT_OVF_EN
      check("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
`endif
      rst = 1'b0;

      // Asynchronous reset with three beats in flight
      for (int j = 0; j < 3; j++) begin
         in_valid = 1'b1;
         in_data  = 32'(j + 5);
         shamt    = 5'd1;
         step();
      end
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_out", out_data, 32'd0);
      check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      #2 rst = 1'b0;
      for (int j = 0; j < 8; j++) begin
         step();
         check("midrst_no_stale", {31'd0, out_valid}, 32'd0);
      end

      // Latency: 1 << 31 appears after the fifth edge
      in_valid = 1'b1;
      in_data  = 32'h0000_0001;
      shamt    = 5'd31;
      step();
      in_valid = 1'b0;
      check("lat_valid_1", {31'd0, out_valid}, 32'd0);
      for (int i = 2; i <= 5; i++) begin
         step();
         if (i < 5) begin
            check("lat_early", {31'd0, out_valid}, 32'd0);
         end else begin
            check("lat_valid_5", {31'd0, out_valid}, 32'd1);
            check("lat_out", out_data, 32'h8000_0000);
         end
      end
      step();
      check("lat_single", {31'd0, out_valid}, 32'd0);

      // Back-to-back sweep of shamt 0..31
      for (int c = 0; c < 36; c++) begin
         if (c < 32) begin
            in_valid = 1'b1;
            in_data  = 32'hDEAD_BEEF;
            shamt    = 5'(c);
         end else begin
            in_valid = 1'b0;
         end
         step();
         if (c >= 4) begin
            exp = 32'hDEAD_BEEF << (c - 4);
            check($sformatf("sweep_valid_%0d", c - 4), {31'd0, out_valid}, 32'd1);
            check($sformatf("sweep_out_%0d", c - 4), out_data, exp);
         end
      end
      step();
      check("sweep_end", {31'd0, out_valid}, 32'd0);

      // Backpressure: stall 4 cycles with a full pipeline and a pending beat
      for (int j = 0; j < 5; j++) begin
         in_valid = 1'b1;
         in_data  = 32'(j + 1);
         shamt    = 5'd1;
         step();
      end
      check("bp_full_valid", {31'd0, out_valid}, 32'd1);
      check("bp_full_out", out_data, 32'd2);
      out_ready = 1'b0;
      in_data   = 32'd6;
      #1;
      check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      for (int j = 0; j < 4; j++) begin
         step();
         check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
         check("bp_hold_out", out_data, 32'd2);
         check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      #1;
      check("bp_in_ready_high", {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      for (int j = 1; j <= 5; j++) begin
         check($sformatf("bp_resume_valid_%0d", j), {31'd0, out_valid}, 32'd1);
         check($sformatf("bp_resume_out_%0d", j), out_data, 32'((j + 1) * 2));
         step();
      end
      check("bp_drained", {31'd0, out_valid}, 32'd0);

      // Bubbles travel with the stream
      for (int c = 0; c < 9; c++) begin
         in_valid = (c < 4) && (c % 2 == 0);
         in_data  = 32'd3;
         shamt    = 5'd2;
         step();
         if (c >= 4) begin
            exp_v = ((c - 4) < 4) && ((c - 4) % 2 == 0);
            check($sformatf("bubble_valid_%0d", c), {31'd0, out_valid}, {31'd0, exp_v});
            if (exp_v) begin
               check($sformatf("bubble_out_%0d", c), out_data, 32'd12);
            end
         end
      end

`ifdef DL_LSHIFT_OVF_EN
      // Overflow flag
      in_valid = 1'b1;
      in_data  = 32'h8000_0000;
      shamt    = 5'd1;
      step();
      in_data  = 32'h0000_FFFF;
      shamt    = 5'd16;
      step();
      in_valid = 1'b0;
      repeat (3) step();
      check("ovf_a_out", out_data, 32'd0);
      check("ovf_a_flag", {31'd0, out_ovf}, 32'd1);
      step();
      check("ovf_b_out", out_data, 32'hFFFF_0000);
      check("ovf_b_flag", {31'd0, out_ovf}, 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
